// File: rtl/riscv_mini_pkg.sv
// Shared encodings for the RISCV-Mini multi-cycle control path:
// FSM states, instruction classes, opcode values and ALU/PC select codes.
package riscv_mini_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    // Instruction class held for the whole instruction once decoded.
    typedef enum logic [1:0] {
        C_R   = 2'd0,
        C_LW  = 2'd1,
        C_SW  = 2'd2,
        C_BEQ = 2'd3
    } iclass_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic PCSEL_PLUS4  = 1'b0;
    localparam logic PCSEL_BRANCH = 1'b1;

    // Datapath strobe bundle driven by the sequencer.
    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_sel;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: maps IR[6:0] to an instruction class
// and flags whether the opcode is one the sequencer can execute.
module opcode_class_decode
    import riscv_mini_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    iclass,
    output logic       legal
);

    // Unsupported opcodes report class R with legal low; the caller traps.
    always_comb begin
        iclass = C_R;
        legal  = 1'b0;
        case (opcode)
            OP_R: begin
                iclass = C_R;
                legal  = 1'b1;
            end
            OP_LW: begin
                iclass = C_LW;
                legal  = 1'b1;
            end
            OP_SW: begin
                iclass = C_SW;
                legal  = 1'b1;
            end
            OP_BEQ: begin
                iclass = C_BEQ;
                legal  = 1'b1;
            end
            default: begin
                iclass = C_R;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for RISCV-Mini. Walks FETCH/DECODE/EXEC/MEM/WB,
// time-sharing one ALU, and handshakes with instruction and data memory.
// Illegal opcodes park the FSM in TRAP until reset.
module multicycle_control
    import riscv_mini_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        alu_zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSel,
    output logic [1:0]  ALUOp,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        busy,
    output logic        trap,
    output logic [31:0] instret
);

    state_t      state;
    iclass_t     cls_q;
    iclass_t     dec_cls;
    logic        dec_legal;
    logic        retire;
    state_t      after_retire;
    logic [31:0] instret_q;
    ctrl_t       ctrl;

    opcode_class_decode u_dec (
        .opcode (opcode),
        .iclass (dec_cls),
        .legal  (dec_legal)
    );

    // Retire is the last cycle of an instruction; run is only looked at here
    // and in IDLE, so dropping it mid-instruction lets the instruction finish.
    always_comb begin
        retire = ((state == S_EXEC) && (cls_q == C_BEQ))
              || ((state == S_MEM) && (cls_q == C_SW) && dmem_ready)
              || (state == S_WB);
        after_retire = run ? S_FETCH : S_IDLE;
    end

    // Sequencer state and class register; class is frozen at DECODE so later
    // opcode changes cannot disturb the running instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cls_q <= C_R;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec_legal) begin
                        cls_q <= dec_cls;
                        state <= S_EXEC;
                    end else begin
                        state <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    case (cls_q)
                        C_R:        state <= S_WB;
                        C_LW, C_SW: state <= S_MEM;
                        default:    state <= after_retire;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) state <= (cls_q == C_LW) ? S_WB : after_retire;
                end
                S_WB: begin
                    state <= after_retire;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Retired-instruction counter; reset wins over a coincident retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    // Strobe decode: Moore on state/class, except the FETCH strobes (imem_ready)
    // and the branch PC load (alu_zero). Reset suppresses every strobe so an
    // aborted instruction leaves no architectural side effect.
    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            S_FETCH: begin
                ctrl.imem_req = 1'b1;
                if (imem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_sel   = PCSEL_PLUS4;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        ctrl.alu_op  = ALUOP_FUNCT;
                        ctrl.alu_src = 1'b0;
                    end
                    C_LW, C_SW: begin
                        ctrl.alu_op  = ALUOP_ADD;
                        ctrl.alu_src = 1'b1;
                    end
                    default: begin
                        ctrl.alu_op   = ALUOP_SUB;
                        ctrl.alu_src  = 1'b0;
                        ctrl.pc_sel   = PCSEL_BRANCH;
                        ctrl.pc_write = alu_zero;
                    end
                endcase
            end
            S_MEM: begin
                ctrl.dmem_req  = 1'b1;
                ctrl.mem_write = (cls_q == C_SW);
            end
            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (cls_q == C_LW);
            end
            default: begin
                ctrl = CTRL_NONE;
            end
        endcase
        if (reset) ctrl = CTRL_NONE;
    end

    assign imem_req = ctrl.imem_req;
    assign dmem_req = ctrl.dmem_req;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign PCWrite  = ctrl.pc_write;
    assign PCSel    = ctrl.pc_sel;
    assign ALUOp    = ctrl.alu_op;
    assign ALUSrc   = ctrl.alu_src;
    assign RegWrite = ctrl.reg_write;
    assign MemtoReg = ctrl.mem_to_reg;
    assign busy     = (state != S_IDLE) && (state != S_TRAP);
    assign trap     = (state == S_TRAP);
    assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle vector bench for multicycle_control. Each row holds the
// inputs for one cycle and the strobes/counter expected in that cycle.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset, run, alu_zero, imem_ready, dmem_ready;
    logic [6:0]  opcode;
    logic        imem_req, dmem_req, MemWrite, IRWrite, PCWrite, PCSel;
    logic [1:0]  ALUOp;
    logic        ALUSrc, RegWrite, MemtoReg, busy, trap;
    logic [31:0] instret;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .opcode     (opcode),
        .alu_zero   (alu_zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCSel      (PCSel),
        .ALUOp      (ALUOp),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .busy       (busy),
        .trap       (trap),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    // {imem_req dmem_req MemWrite IRWrite PCWrite PCSel ALUOp[1:0] ALUSrc RegWrite MemtoReg busy trap}
    logic [12:0] act;
    assign act = {imem_req, dmem_req, MemWrite, IRWrite, PCWrite, PCSel,
                  ALUOp, ALUSrc, RegWrite, MemtoReg, busy, trap};

    localparam logic [12:0] X_IDLE = 13'b0_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] X_FW   = 13'b1_0_0_0_0_0_00_0_0_0_1_0;
    localparam logic [12:0] X_FR   = 13'b1_0_0_1_1_0_00_0_0_0_1_0;
    localparam logic [12:0] X_BUSY = 13'b0_0_0_0_0_0_00_0_0_0_1_0;
    localparam logic [12:0] X_EXR  = 13'b0_0_0_0_0_0_10_0_0_0_1_0;
    localparam logic [12:0] X_EXM  = 13'b0_0_0_0_0_0_00_1_0_0_1_0;
    localparam logic [12:0] X_EXB1 = 13'b0_0_0_0_1_1_01_0_0_0_1_0;
    localparam logic [12:0] X_EXB0 = 13'b0_0_0_0_0_1_01_0_0_0_1_0;
    localparam logic [12:0] X_MLW  = 13'b0_1_0_0_0_0_00_0_0_0_1_0;
    localparam logic [12:0] X_MSW  = 13'b0_1_1_0_0_0_00_0_0_0_1_0;
    localparam logic [12:0] X_WBR  = 13'b0_0_0_0_0_0_00_0_1_0_1_0;
    localparam logic [12:0] X_WBL  = 13'b0_0_0_0_0_0_00_0_1_1_1_0;
    localparam logic [12:0] X_TRAP = 13'b0_0_0_0_0_0_00_0_0_0_0_1;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] ILL = 7'b0010011;
    localparam logic [31:0] FF = 32'hFFFF_FFFF;

    typedef struct {
        string       tag;
        logic        rst, run, ir, dr, az;
        logic [6:0]  op;
        logic [12:0] exp;
        logic [31:0] ins;
    } vec_t;

    typedef struct {
        string       tag;
        logic [12:0] exp;
        logic [31:0] ins;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   passed = 0;
    int   wrap_idx;

    task automatic add(input string tag, input logic rst, input logic rn, input logic ir,
                       input logic dr, input logic az, input logic [6:0] op,
                       input logic [12:0] exp, input logic [31:0] ins);
        vec_t v;
        v.tag = tag; v.rst = rst; v.run = rn; v.ir = ir; v.dr = dr; v.az = az;
        v.op = op; v.exp = exp; v.ins = ins;
        vecs.push_back(v);
    endtask

    // Drive one cycle after the rising edge, queue its expectation, and
    // compare on the falling edge of the same cycle.
    task automatic apply(input vec_t v);
        sb_t e;
        @(posedge clk);
        #1;
        reset = v.rst; run = v.run; imem_ready = v.ir; dmem_ready = v.dr;
        alu_zero = v.az; opcode = v.op;
        e.tag = v.tag; e.exp = v.exp; e.ins = v.ins;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        checks++;
        if (act === e.exp) passed++;
        else $display("FAIL %s strobes: got %b want %b", e.tag, act, e.exp);
        checks++;
        if (instret === e.ins) passed++;
        else $display("FAIL %s instret: got %h want %h", e.tag, instret, e.ins);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        alu_zero = 1'b0; opcode = 7'd0;

        //   tag            rst run ir dr az op   exp     instret
        add("reset",         1, 0, 0, 0, 0, 0,   X_IDLE, 0);
        // R-type, zero-wait
        add("r_idle",        0, 1, 0, 0, 0, 0,   X_IDLE, 0);
        add("r_fetch",       0, 1, 1, 0, 0, 0,   X_FR,   0);
        add("r_dec",         0, 1, 0, 0, 0, R,   X_BUSY, 0);
        add("r_exec",        0, 1, 0, 0, 0, R,   X_EXR,  0);
        add("r_wb",          0, 1, 0, 0, 0, R,   X_WBR,  0);
        // LW with one fetch wait and three data waits
        add("lw_fwait",      0, 1, 0, 0, 0, 0,   X_FW,   1);
        add("lw_fetch",      0, 1, 1, 0, 0, 0,   X_FR,   1);
        add("lw_dec",        0, 1, 0, 0, 0, LW,  X_BUSY, 1);
        add("lw_exec",       0, 1, 0, 0, 0, LW,  X_EXM,  1);
        for (int k = 0; k < 3; k++)
            add("lw_mwait",  0, 1, 0, 0, 0, LW,  X_MLW,  1);
        add("lw_mem",        0, 1, 0, 1, 0, LW,  X_MLW,  1);
        add("lw_wb",         0, 1, 0, 0, 0, LW,  X_WBL,  1);
        // BEQ taken then not taken; opcode change after DECODE ignored
        add("beq1_fetch",    0, 1, 1, 0, 0, 0,   X_FR,   2);
        add("beq1_dec",      0, 1, 0, 0, 0, BQ,  X_BUSY, 2);
        add("beq1_exec",     0, 1, 0, 0, 1, BQ,  X_EXB1, 2);
        add("beq0_fetch",    0, 1, 1, 0, 0, 0,   X_FR,   3);
        add("beq0_dec",      0, 1, 0, 0, 0, BQ,  X_BUSY, 3);
        add("beq0_exec",     0, 0, 0, 0, 0, R,   X_EXB0, 3);
        add("idle_hold",     0, 0, 1, 1, 1, 0,   X_IDLE, 4);
        // SW with run dropped in EXEC: completes, then IDLE
        add("sw_idle",       0, 1, 0, 0, 0, 0,   X_IDLE, 4);
        add("sw_fetch",      0, 1, 1, 0, 0, 0,   X_FR,   4);
        add("sw_dec",        0, 1, 0, 0, 0, SW,  X_BUSY, 4);
        add("sw_exec",       0, 0, 0, 0, 0, SW,  X_EXM,  4);
        add("sw_mem",        0, 0, 0, 1, 0, SW,  X_MSW,  4);
        add("sw_done",       0, 0, 0, 0, 0, 0,   X_IDLE, 5);
        // Illegal opcode traps and holds until reset
        add("t_idle",        0, 1, 0, 0, 0, 0,   X_IDLE, 5);
        add("t_fetch",       0, 1, 1, 0, 0, 0,   X_FR,   5);
        add("t_dec",         0, 1, 0, 0, 0, ILL, X_BUSY, 5);
        for (int k = 0; k < 10; k++)
            add("t_hold",    0, 1, 1, 1, 1, R,   X_TRAP, 5);
        add("t_reset",       1, 1, 1, 1, 1, R,   X_TRAP, 5);
        add("t_after",       0, 0, 0, 0, 0, 0,   X_IDLE, 0);
        // Reset during MEM of SW (data ready in the same cycle)
        add("rs_idle",       0, 1, 0, 0, 0, 0,   X_IDLE, 0);
        add("rs_fetch",      0, 1, 1, 0, 0, 0,   X_FR,   0);
        add("rs_dec",        0, 1, 0, 0, 0, SW,  X_BUSY, 0);
        add("rs_exec",       0, 1, 0, 0, 0, SW,  X_EXM,  0);
        add("rs_mwait",      0, 1, 0, 0, 0, SW,  X_MSW,  0);
        add("rs_reset",      1, 1, 0, 1, 0, SW,  X_BUSY, 0);
        add("rs_after",      0, 0, 0, 0, 0, 0,   X_IDLE, 0);
        // Counter wrap: preset to all-ones, retire one SW
        wrap_idx = vecs.size();
        add("w_idle",        0, 1, 0, 0, 0, 0,   X_IDLE, FF);
        add("w_fetch",       0, 1, 1, 0, 0, 0,   X_FR,   FF);
        add("w_dec",         0, 1, 0, 0, 0, SW,  X_BUSY, FF);
        add("w_exec",        0, 1, 0, 0, 0, SW,  X_EXM,  FF);
        add("w_mem",         0, 0, 0, 1, 0, SW,  X_MSW,  FF);
        add("w_done",        0, 0, 0, 0, 0, 0,   X_IDLE, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == wrap_idx) begin
                force dut.instret_q = 32'hFFFF_FFFF;
                @(posedge clk);
                #1;
                release dut.instret_q;
            end
            apply(vecs[i]);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RISCV-Mini core that time-shares the single ALU across fetch, execute and address phases. It drives `ALUOp` into the ALU control decoder and generates the register-file, memory, IR and PC strobes for each phase. It also handshakes with instruction and data memories and raises a sticky trap on unsupported opcodes. It sits between the IR/opcode field and the datapath mux/enable inputs.

## Interface
- No parameters; opcode, state and `ALUOp` encodings come from the shared package.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; permits fetch of the next instruction.
- `opcode` in 7: `IR[6:0]`, valid from DECODE onward.
- `alu_zero` in 1: ALU zero flag, sampled in EXEC.
- `imem_ready` in 1: instruction memory data valid.
- `dmem_ready` in 1: data memory access complete.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `MemWrite` out 1: data access is a store (qualifies `dmem_req`).
- `IRWrite` out 1: load IR.
- `PCWrite` out 1: load PC.
- `PCSel` out 1: 0 = PC+4, 1 = branch target.
- `ALUOp` out 2: 00 add, 01 sub, 10 funct-decoded.
- `ALUSrc` out 1: ALU B operand, 0 = rs2, 1 = immediate.
- `RegWrite` out 1: register file write enable.
- `MemtoReg` out 1: writeback source, 0 = ALU result, 1 = load data.
- `busy` out 1: state is not IDLE and not TRAP.
- `trap` out 1: sticky illegal-opcode flag.
- `instret` out 32: retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. All outputs default to 0 unless stated for a state.
- Supported opcodes: R 0110011, LW 0000011, SW 0100011, BEQ 1100011.
- IDLE: `run`=1 → FETCH.
- FETCH: `imem_req`=1.
  - While `imem_ready`=0, stay in FETCH.
  - On `imem_ready`: `IRWrite`=1, `PCWrite`=1, `PCSel`=0 → DECODE.
- DECODE: opcode supported → EXEC; otherwise → TRAP. No strobes.
- EXEC:
  - R: `ALUOp`=10, `ALUSrc`=0 → WB.
  - LW/SW: `ALUOp`=00, `ALUSrc`=1 → MEM.
  - BEQ: `ALUOp`=01, `ALUSrc`=0, `PCSel`=1, `PCWrite`=`alu_zero` → retire.
- MEM: `dmem_req`=1, `MemWrite`=(SW).
  - While `dmem_ready`=0, stay in MEM.
  - On `dmem_ready`: LW → WB; SW → retire.
- WB: `RegWrite`=1, `MemtoReg`=(LW) → retire.
- Retire: `instret` += 1 (wraps 0xFFFF_FFFF → 0). Next state is FETCH if `run`=1, else IDLE.
- TRAP: all strobes 0; held until `reset`. `trap`=1.
- Instruction class is captured from `opcode` in DECODE into a 2-bit register. `opcode` changes after DECODE are ignored.

## Timing
- Reset (synchronous): state=IDLE, `instret`=0, `trap`=0, every strobe 0.
  - `reset` asserted mid-instruction aborts it: no `RegWrite`, `PCWrite` or `MemWrite` in the reset cycle, and no retire count.
- Strobes are Moore decodes of state and class, except `IRWrite`/`PCWrite` in FETCH (gated by `imem_ready`) and BEQ `PCWrite` (gated by `alu_zero`).
- Latency with zero-wait memories, counting the FETCH cycle through the retire cycle: R 4, LW 5, SW 4, BEQ 3.
- Each wait cycle on `imem_ready`/`dmem_ready` adds exactly one cycle. Requests stay asserted and steady while waiting.
- `run` is sampled only in IDLE and at retire. Deasserting `run` mid-instruction lets that instruction complete.
- `instret` updates on the clock edge that leaves the retire state. It is visible the following cycle.

## Structure
- `riscv_mini_pkg`: state enum, instruction-class enum, opcode constants, `ALUOp` constants (ADD=00, SUB=01, FUNCT=10), `PCSel` constants.
- One sub-module: `opcode_class_decode`. Combinational; maps `opcode` to class plus a legal flag. It is reused by the trap logic.
- The FSM, class register and `instret` counter live in the top module. Target size is about 200 lines.

## Test plan
- R-type, `run`=1, zero-wait memories: FETCH/DECODE/EXEC/WB in 4 cycles; `ALUOp`=10 in EXEC; `RegWrite`=1 only in WB; `instret` 0→1.
- LW with `dmem_ready` delayed 3 cycles: `dmem_req` held 4 cycles, then `RegWrite`=1 with `MemtoReg`=1; total 8 cycles.
- BEQ with `alu_zero`=1, then BEQ with `alu_zero`=0: `PCWrite`=1 with `PCSel`=1 only in the first EXEC; both retire.
- Opcode 0010011: DECODE → TRAP, `trap`=1, `busy`=0, `instret` unchanged; stays in TRAP through 10 cycles of `run`=1 until `reset`.
- `reset` pulsed during MEM of an SW: `MemWrite`=0 from the reset edge, state IDLE, `instret`=0.
- `instret` preset to 0xFFFF_FFFF by forcing, then one SW retires: counter wraps to 0. Separately, `run` dropped during EXEC: the instruction completes, then the FSM enters IDLE.
